// File: rtl/wb_ctrl.sv
// Writeback-stage controller: registers the MEM/WB result, stalls MEM while a
// load waits for data memory, and drops the writeback with mem_err on timeout.
module wb_ctrl #(
    parameter int WIDTH    = 5,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_m,
    input  logic             MemToReg_m,
    input  logic             RegWrite_m,
    input  logic [4:0]       WriteReg_m,
    input  logic [WIDTH-1:0] data_mem,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] data_alu,
    output logic             stall_m,
    output logic             MemToReg_w,
    output logic             RegWrite_w,
    output logic [4:0]       WriteReg_w,
    output logic [WIDTH-1:0] result_w,
    output logic             mem_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             pend_we_reg, pend_we_next;
    logic [4:0]       pend_dst_reg, pend_dst_next;
    logic             memtoreg_reg, memtoreg_next;
    logic             regwrite_reg, regwrite_next;
    logic [4:0]       writereg_reg, writereg_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             mem_err_reg, mem_err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            pend_we_reg  <= 1'b0;
            pend_dst_reg <= '0;
            memtoreg_reg <= 1'b0;
            regwrite_reg <= 1'b0;
            writereg_reg <= '0;
            result_reg   <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            pend_we_reg  <= pend_we_next;
            pend_dst_reg <= pend_dst_next;
            memtoreg_reg <= memtoreg_next;
            regwrite_reg <= regwrite_next;
            writereg_reg <= writereg_next;
            result_reg   <= result_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        pend_we_next  = pend_we_reg;
        pend_dst_next = pend_dst_reg;
        memtoreg_next = memtoreg_reg;
        writereg_next = writereg_reg;
        result_next   = result_reg;
        regwrite_next = 1'b0;
        mem_err_next  = 1'b0;
        stall_m       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (valid_m) begin
                    if (MemToReg_m && !mem_ready) begin
                        // Write enable is folded with the r0 check at issue time.
                        stall_m       = 1'b1;
                        state_next    = WAIT_MEM;
                        wait_cnt_next = CNT_W'(1);
                        pend_we_next  = RegWrite_m && (WriteReg_m != 5'd0);
                        pend_dst_next = WriteReg_m;
                    end else begin
                        result_next   = MemToReg_m ? data_mem : data_alu;
                        memtoreg_next = MemToReg_m;
                        writereg_next = WriteReg_m;
                        regwrite_next = RegWrite_m && (WriteReg_m != 5'd0);
                    end
                end
            end
            WAIT_MEM: begin
                stall_m = 1'b1;
                if (mem_ready) begin
                    result_next   = data_mem;
                    memtoreg_next = 1'b1;
                    writereg_next = pend_dst_reg;
                    regwrite_next = pend_we_reg;
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == LAST_CNT) begin
                    mem_err_next  = 1'b1;
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy       = (state_reg == WAIT_MEM);
    assign MemToReg_w = memtoreg_reg;
    assign RegWrite_w = regwrite_reg;
    assign WriteReg_w = writereg_reg;
    assign result_w   = result_reg;
    assign mem_err    = mem_err_reg;

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model of the writeback stage.
module tb_wb_ctrl;
    localparam int WIDTH    = 5;
    localparam int MAX_WAIT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             valid_m = 1'b0, MemToReg_m = 1'b0, RegWrite_m = 1'b0;
    logic [4:0]       WriteReg_m = '0;
    logic [WIDTH-1:0] data_mem = '0, data_alu = '0;
    logic             mem_ready = 1'b0;
    logic             stall_m, MemToReg_w, RegWrite_w, mem_err, busy;
    logic [4:0]       WriteReg_w;
    logic [WIDTH-1:0] result_w;

    always #5 clk = ~clk;

    wb_ctrl #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .MemToReg_m(MemToReg_m),
        .RegWrite_m(RegWrite_m), .WriteReg_m(WriteReg_m), .data_mem(data_mem),
        .mem_ready(mem_ready), .data_alu(data_alu), .stall_m(stall_m),
        .MemToReg_w(MemToReg_w), .RegWrite_w(RegWrite_w), .WriteReg_w(WriteReg_w),
        .result_w(result_w), .mem_err(mem_err), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: a load is either outstanding (with its issue cycle) or not.
    bit               m_waiting;
    int               m_issue_cyc;
    bit               m_pend_we;
    logic [4:0]       m_pend_dst;
    logic             m_mtr, m_rw, m_err;
    logic [4:0]       m_wr;
    logic [WIDTH-1:0] m_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_waiting = 0; m_issue_cyc = 0; m_pend_we = 0; m_pend_dst = '0;
        m_mtr = 0; m_rw = 0; m_err = 0; m_wr = '0; m_res = '0;
    endfunction

    function automatic void retire(input logic mtr, input logic [WIDTH-1:0] res,
                                   input logic [4:0] dst, input bit we);
        m_mtr = mtr; m_res = res; m_wr = dst; m_rw = we;
        $display("cyc %0d retire: dst=%0d data=%0d mem=%0d we=%0d", cyc, dst, res, mtr, we);
    endfunction

    task automatic check_outputs();
        check("stall_m", stall_m, m_waiting | (valid_m & MemToReg_m & ~mem_ready));
        check("busy", busy, m_waiting);
        check("MemToReg_w", MemToReg_w, m_mtr);
        check("RegWrite_w", RegWrite_w, m_rw);
        check("WriteReg_w", WriteReg_w, m_wr);
        check("result_w", result_w, m_res);
        check("mem_err", mem_err, m_err);
    endtask

    function automatic void model_step();
        bit we;
        m_rw  = 0;
        m_err = 0;
        we = RegWrite_m && (WriteReg_m != 0);
        if (!m_waiting) begin
            if (valid_m) begin
                if (!MemToReg_m)    retire(1'b0, data_alu, WriteReg_m, we);
                else if (mem_ready) retire(1'b1, data_mem, WriteReg_m, we);
                else begin
                    m_waiting = 1; m_issue_cyc = cyc; m_pend_we = we; m_pend_dst = WriteReg_m;
                end
            end
        end else if (mem_ready) begin
            retire(1'b1, data_mem, m_pend_dst, m_pend_we);
            m_waiting = 0;
        end else if (cyc - m_issue_cyc == MAX_WAIT - 1) begin
            m_err = 1; m_waiting = 0;
            $display("cyc %0d load timeout: dst=%0d", cyc, m_pend_dst);
        end
    endfunction

    task automatic cycle(input logic v, input logic mtr, input logic rw, input logic [4:0] wr,
                         input logic [WIDTH-1:0] dm, input logic rdy, input logic [WIDTH-1:0] da);
        valid_m = v; MemToReg_m = mtr; RegWrite_m = rw; WriteReg_m = wr;
        data_mem = dm; mem_ready = rdy; data_alu = da;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        valid_m = 0; MemToReg_m = 0; mem_ready = 0; RegWrite_m = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst stall_m", stall_m, 0);
        check("rst busy", busy, 0);
        check("rst MemToReg_w", MemToReg_w, 0);
        check("rst RegWrite_w", RegWrite_w, 0);
        check("rst WriteReg_w", WriteReg_w, 0);
        check("rst result_w", result_w, 0);
        check("rst mem_err", mem_err, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // ALU op
        cycle(1, 0, 1, 5'd3, 5'd0, 0, 5'd6);
        check("alu result", result_w, 6);
        check("alu we", RegWrite_w, 1);
        cycle(0, 0, 0, 5'd0, 5'd0, 0, 5'd0);

        // Ready load: memory data wins over the ALU value
        cycle(1, 1, 1, 5'd7, 5'd11, 1, 5'd24);
        check("ld result", result_w, 11);
        cycle(0, 0, 0, 5'd0, 5'd0, 0, 5'd0);

        // Delayed load, data arrives 3 cycles after issue, then ALU op
        cycle(1, 1, 1, 5'd9, 5'd0, 0, 5'd0);
        cycle(1, 0, 1, 5'd1, 5'd0, 0, 5'd2);
        cycle(1, 0, 1, 5'd1, 5'd0, 0, 5'd2);
        cycle(1, 0, 1, 5'd1, 5'd23, 1, 5'd2);
        check("dly result", result_w, 23);
        check("dly dst", WriteReg_w, 9);
        cycle(1, 0, 1, 5'd4, 5'd0, 0, 5'd17);
        check("dly next alu", result_w, 17);
        cycle(0, 0, 0, 5'd0, 5'd0, 0, 5'd0);

        // Timeout: memory never answers
        cycle(1, 1, 1, 5'd12, 5'd0, 0, 5'd0);
        for (int i = 0; i < MAX_WAIT; i++) cycle(0, 0, 0, 5'd0, 5'd5, 0, 5'd0);
        cycle(0, 0, 0, 5'd0, 5'd0, 0, 5'd0);

        // Tie: data arrives exactly on the last wait cycle
        cycle(1, 1, 1, 5'd13, 5'd0, 0, 5'd0);
        for (int i = 0; i < MAX_WAIT - 2; i++) cycle(0, 0, 0, 5'd0, 5'd0, 0, 5'd0);
        cycle(0, 0, 0, 5'd0, 5'd19, 1, 5'd0);
        check("tie result", result_w, 19);
        check("tie no err", mem_err, 0);
        cycle(0, 0, 0, 5'd0, 5'd0, 0, 5'd0);

        // Register 0 never writes
        cycle(1, 0, 1, 5'd0, 5'd0, 0, 5'd21);
        check("r0 we", RegWrite_w, 0);
        cycle(0, 0, 0, 5'd0, 5'd0, 0, 5'd0);

        // Reset in the middle of a wait aborts the load
        cycle(1, 1, 1, 5'd14, 5'd0, 0, 5'd0);
        cycle(0, 0, 0, 5'd0, 5'd0, 0, 5'd0);
        do_reset();
        for (int i = 0; i < MAX_WAIT + 2; i++) cycle(0, 0, 0, 5'd0, 5'd0, 0, 5'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 31)), WIDTH'($urandom_range(0, 31)),
                  $urandom_range(0, 2) == 0, WIDTH'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
